ifm_row_feeder: RTL and testbench

IFM_ROW_FEEDER -- requirements
Module: ifm_row_feeder

---
 rtl/ifm_row_feeder.sv | 116 +++++++++++
 tb/tb_ifm_row_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_row_feeder.sv
// rtl/ifm_row_feeder.sv - staging FIFO plus row/column tagger feeding a PE IFM write port
module ifm_row_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      row_len,
    input  logic [LEN_W-1:0]      num_rows,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH+1:0] data_in_ifm,
    output logic                  w_en_ifm,
    input  logic                  ready_ifm,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [LEN_W-1:0]      row_len_q, num_rows_q, col_cnt, row_cnt;
    logic                  cfg_err_q, done_q;

    logic       full, empty, push, pop, cfg_ok, start_ok;
    logic       col_last, row_last, last_xfer;
    logic [1:0] tag;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign cfg_ok    = (row_len != '0) && (num_rows != '0);
    assign col_last  = (col_cnt == row_len_q - LEN_W'(1));
    assign row_last  = (row_cnt == num_rows_q - LEN_W'(1));
    assign tag       = {col_cnt == '0, col_last};

    // Outputs are forced to their idle values while rst is held, whatever the state.
    assign in_ready    = rst || !full;
    assign w_en_ifm    = !rst && (state_q == RUN) && !empty;
    assign data_in_ifm = w_en_ifm ? {tag, mem[rd_ptr]} : '0;
    assign busy        = !rst && (state_q == RUN);
    assign done        = !rst && done_q;
    assign cfg_err     = cfg_err_q;

    // Push uses the pre-pop full flag, so a full FIFO never accepts even while draining.
    assign push      = in_valid && !full;
    assign pop       = w_en_ifm && ready_ifm;
    assign last_xfer = pop && col_last && row_last;

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d  = RUN;
                    start_ok = 1'b1;
                end
            end
            RUN: begin
                if (last_xfer) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            row_len_q  <= '0;
            num_rows_q <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            cfg_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_xfer;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if ((state_q == IDLE) && start && !cfg_ok) cfg_err_q <= 1'b1;
            if (start_ok) begin
                row_len_q  <= row_len;
                num_rows_q <= num_rows;
                col_cnt    <= '0;
                row_cnt    <= '0;
            end else if (pop) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + LEN_W'(1);
                end else begin
                    col_cnt <= col_cnt + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_ifm_row_feeder.sv
// tb/tb_ifm_row_feeder.sv - scenario bench for ifm_row_feeder against a queue-based job model
module tb_ifm_row_feeder;
    localparam int DW = 16;
    localparam int LW = 5;
    localparam int FD = 4;
    localparam int VW = DW + 7;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, ready_ifm;
    logic [LW-1:0] row_len, num_rows;
    logic [DW-1:0] in_data;
    logic          in_ready, w_en_ifm, busy, done, cfg_err;
    logic [DW+1:0] data_in_ifm;

    always #5 clk = ~clk;

    ifm_row_feeder #(.DATA_WIDTH(DW), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .data_in_ifm(data_in_ifm), .w_en_ifm(w_en_ifm), .ready_ifm(ready_ifm),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    wire [VW-1:0] dut_vec = {in_ready, w_en_ifm, data_in_ifm, busy, done, cfg_err};

    int vectors = 0;
    int miscompares = 0;

    // Job model: queued elements, running flag, and index of the next element in the job.
    logic [DW-1:0] mq[$];
    bit m_run, m_err, m_done;
    int m_rl, m_nr, m_idx;

    function automatic logic [VW-1:0] model_vec();
        logic          w;
        logic [DW+1:0] dat;
        int            col;
        w   = m_run && (mq.size() > 0);
        dat = '0;
        if (w) begin
            col = m_idx % m_rl;
            dat = {col == 0, col == m_rl - 1, mq[0]};
        end
        return {mq.size() < FD, w, dat, m_run, m_done, m_err};
    endfunction

    task automatic model_edge();
        bit xfer, psh, was_run;
        xfer    = m_run && (mq.size() > 0) && ready_ifm;
        psh     = in_valid && (mq.size() < FD);
        was_run = m_run;
        m_done  = 0;
        if (rst) begin
            mq.delete();
            m_run = 0;
            m_err = 0;
            m_idx = 0;
        end else begin
            if (xfer) begin
                void'(mq.pop_front());
                m_idx++;
                if (m_idx == m_rl * m_nr) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
            if (psh) mq.push_back(in_data);
            if (!was_run && start) begin
                if (row_len == 0 || num_rows == 0) begin
                    m_err = 1;
                end else begin
                    m_run = 1;
                    m_rl  = int'(row_len);
                    m_nr  = int'(num_rows);
                    m_idx = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [DW-1:0] d, input bit rdy,
                         input bit s, input int rl, input int nr);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        ready_ifm = rdy;
        start     = s;
        row_len   = LW'(rl);
        num_rows  = LW'(nr);
        #3;
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
            clk_edge();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 3, 2);
            vectors++;
            if ({in_ready, w_en_ifm, data_in_ifm, busy, done} !== {2'b10, {(DW+2){1'b0}}, 2'b00}) begin
                miscompares++;
                $display("FAIL reset_hold: got %h required %h", {in_ready, w_en_ifm, data_in_ifm, busy, done},
                         {2'b10, {(DW+2){1'b0}}, 2'b00});
            end
            clk_edge();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, 0);
        vectors++;
        if (dut_vec !== {2'b10, {(DW+2){1'b0}}, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_after: got %h required %h", dut_vec, {2'b10, {(DW+2){1'b0}}, 3'b000});
        end
        clk_edge();
    endtask

    task automatic test_single_row();
        logic [DW+1:0] seen[$];
        logic [DW+1:0] exp_seq [4];
        int first_xfer, done_cyc, done_cnt;
        exp_seq = '{{2'b10, 16'd5}, {2'b00, 16'd6}, {2'b00, 16'd7}, {2'b01, 16'd8}};
        first_xfer = -1; done_cyc = -1; done_cnt = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b0, c >= 1 && c <= 4, DW'(c + 4), 1'b1, c == 0, 4, 1);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL single_row_c%0d: got %h expected %h", c, dut_vec, model_vec());
            end
            if (w_en_ifm && ready_ifm) begin
                if (first_xfer < 0) first_xfer = c;
                seen.push_back(data_in_ifm);
            end
            if (done) begin done_cnt++; done_cyc = c; end
            clk_edge();
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= seen.size() || seen[i] !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL single_row_elem%0d: got %h required %h", i, (i < seen.size()) ? seen[i] : '0, exp_seq[i]);
            end
        end
        vectors++;
        if (first_xfer != 2 || done_cyc != 6 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL single_row_timing: got first=%0d done=%0d n=%0d required 2 6 1", first_xfer, done_cyc, done_cnt);
        end
    endtask

    task automatic test_row_len_one();
        logic [DW+1:0] seen[$];
        int done_cyc, done_cnt;
        done_cyc = -1; done_cnt = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, c >= 1 && c <= 3, DW'(c), 1'b1, c == 0, 1, 3);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL row_len_one_c%0d: got %h expected %h", c, dut_vec, model_vec());
            end
            if (w_en_ifm && ready_ifm) seen.push_back(data_in_ifm);
            if (done) begin done_cnt++; done_cyc = c; end
            clk_edge();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= seen.size() || seen[i] !== {2'b11, DW'(i + 1)}) begin
                miscompares++;
                $display("FAIL row_len_one_elem%0d: got %h required %h", i, (i < seen.size()) ? seen[i] : '0, {2'b11, DW'(i + 1)});
            end
        end
        vectors++;
        if (seen.size() != 3 || done_cnt != 1 || done_cyc != 5) begin
            miscompares++;
            $display("FAIL row_len_one_count: got n=%0d done=%0d at %0d required 3 1 5", seen.size(), done_cnt, done_cyc);
        end
    endtask

    task automatic test_full_preload();
        logic [DW+1:0] seen[$];
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, c <= 4, DW'(16'h100 + c), 1'b1, c == 5, 4, 1);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL preload_c%0d: got %h expected %h", c, dut_vec, model_vec());
            end
            if ((c == 4 || c == 6) && in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL preload_full_c%0d: got in_ready %b required 0", c, in_ready);
            end
            if (c == 7 && in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL preload_reopen: got in_ready %b required 1", in_ready);
            end
            if (c == 4 || c == 6 || c == 7) vectors++;
            if (w_en_ifm && ready_ifm) seen.push_back(data_in_ifm);
            clk_edge();
        end
        vectors++;
        if (seen.size() != 4 || seen[3] !== {2'b01, 16'h103}) begin
            miscompares++;
            $display("FAIL preload_drain: got n=%0d last=%h required 4 %h", seen.size(),
                     (seen.size() > 0) ? seen[seen.size() - 1] : '0, {2'b01, 16'h103});
        end
    endtask

    task automatic test_backpressure();
        logic [DW+1:0] seen[$];
        int done_cyc;
        done_cyc = -1;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, c <= 3, DW'(16'h200 + c), !(c >= 6 && c <= 8), c == 4, 4, 1);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL backpressure_c%0d: got %h expected %h", c, dut_vec, model_vec());
            end
            if (c >= 6 && c <= 8) begin
                vectors++;
                if ({w_en_ifm, data_in_ifm} !== {1'b1, 2'b00, 16'h201}) begin
                    miscompares++;
                    $display("FAIL backpressure_hold_c%0d: got %h required %h", c, {w_en_ifm, data_in_ifm}, {1'b1, 2'b00, 16'h201});
                end
            end
            if (w_en_ifm && ready_ifm) seen.push_back(data_in_ifm);
            if (done) done_cyc = c;
            clk_edge();
        end
        vectors++;
        if (seen.size() != 4 || seen[1] !== {2'b00, 16'h201} || seen[3] !== {2'b01, 16'h203} || done_cyc != 12) begin
            miscompares++;
            $display("FAIL backpressure_stream: got n=%0d done=%0d required 4 elements, done at 12", seen.size(), done_cyc);
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, c == 1, 16'h0055, 1'b1, c == 0 || c == 2, (c == 0) ? 0 : 1, (c == 0) ? 2 : 1);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL cfg_err_c%0d: got %h expected %h", c, dut_vec, model_vec());
            end
            if (c == 1 || c == 2) begin
                vectors++;
                if ({cfg_err, busy, w_en_ifm} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL cfg_err_flag_c%0d: got %b required 100", c, {cfg_err, busy, w_en_ifm});
                end
            end
            if (c == 3) begin
                vectors++;
                if ({w_en_ifm, data_in_ifm} !== {1'b1, 2'b11, 16'h0055}) begin
                    miscompares++;
                    $display("FAIL cfg_err_recover: got %h required %h", {w_en_ifm, data_in_ifm}, {1'b1, 2'b11, 16'h0055});
                end
            end
            clk_edge();
        end
    endtask

    task automatic test_reset_midjob();
        int early_done, late_done;
        early_done = 0; late_done = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(c == 7, c <= 3 || (c >= 9 && c <= 11), (c <= 3) ? DW'(16'h400 + c) : DW'(16'h300 + c - 9),
                  1'b1, c == 4 || c == 9, (c == 4) ? 4 : 3, 1);
            if (c == 7 || c == 8) begin
                vectors++;
                if ({in_ready, w_en_ifm, data_in_ifm, busy, done} !== {2'b10, {(DW+2){1'b0}}, 2'b00}) begin
                    miscompares++;
                    $display("FAIL midjob_reset_c%0d: got %h required %h", c,
                             {in_ready, w_en_ifm, data_in_ifm, busy, done}, {2'b10, {(DW+2){1'b0}}, 2'b00});
                end
            end
            if (c != 7) begin
                vectors++;
                if (dut_vec !== model_vec()) begin
                    miscompares++;
                    $display("FAIL midjob_c%0d: got %h expected %h", c, dut_vec, model_vec());
                end
            end
            if (c == 10) begin
                vectors++;
                if ({w_en_ifm, data_in_ifm} !== {1'b1, 2'b10, 16'h300}) begin
                    miscompares++;
                    $display("FAIL midjob_next_first: got %h required %h", {w_en_ifm, data_in_ifm}, {1'b1, 2'b10, 16'h300});
                end
            end
            if (done) begin
                if (c < 9) early_done++;
                else late_done++;
            end
            clk_edge();
        end
        vectors++;
        if (early_done != 0 || late_done != 1) begin
            miscompares++;
            $display("FAIL midjob_done: got aborted=%0d next=%0d required 0 1", early_done, late_done);
        end
    endtask

    task automatic test_random_jobs();
        bit s;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s = m_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
            drive(1'b0, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, s,
                  $urandom_range(0, 6), $urandom_range(1, 3));
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL random_c%0d: got %h expected %h", c, dut_vec, model_vec());
            end
            clk_edge();
        end
    endtask

    initial begin
        m_run = 0; m_err = 0; m_done = 0; m_rl = 1; m_nr = 1; m_idx = 0;
        test_reset();
        test_single_row();
        test_row_len_one();
        test_full_preload();
        test_backpressure();
        test_cfg_err();
        test_reset_midjob();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
